ifetch: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory's PC input. It pairs the memory's registered (1-cycle) instruction output with the PC that produced it and presents the pair to decode through a valid/ready handshake. Branch/jump redirects from later stages retarget fetch with zero bubble, and misaligned targets are flagged and halt fetch.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/ifetch.sv | 80 ++++++++
 tb/tb_ifetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: the canonical NOP, the default boot
// address and the fetch-stage state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, pairs the memory's 1-cycle registered
// read data with its address and hands the pair to decode via valid/ready.
module ifetch
  import riscv_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC[PC_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic                  id_misaligned,
  output logic [31:0]           fetch_count
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] resp_pc_q;
  logic                resp_valid_q;
  fetch_state_e        state;

  logic                stall;
  logic [PC_WIDTH-1:0] pc_inc;

  assign stall = resp_valid_q & ~id_ready;

  // Before the first response exists (only right after reset) re-issue
  // resp_pc_q, which holds RESET_PC, so the first fetch hits the boot address.
  always_comb begin
    imem_pc = pc_q;
    if (redirect_valid)
      imem_pc = redirect_pc;
    else if (stall || state == HALT || !resp_valid_q)
      imem_pc = resp_pc_q;
  end

  assign pc_inc = imem_pc + PC_WIDTH'(4);

  assign id_valid      = resp_valid_q & ~redirect_valid;
  assign id_pc         = resp_pc_q;
  assign id_misaligned = |resp_pc_q[1:0];
  assign id_inst       = id_misaligned ? NOP_INST[INST_WIDTH-1:0] : imem_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC + PC_WIDTH'(4);
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
      state        <= RUN;
      fetch_count  <= 32'd0;
    end else begin
      resp_pc_q <= imem_pc;
      if (id_valid && id_ready)
        fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        pc_q         <= pc_inc;
        resp_valid_q <= 1'b1;
        state        <= (|redirect_pc[1:0]) ? HALT : RUN;
      end else if (state == HALT) begin
        // Hold the misaligned response until decode takes it, then go quiet.
        if (resp_valid_q && id_ready)
          resp_valid_q <= 1'b0;
      end else if (!stall) begin
        pc_q         <= pc_inc;
        resp_valid_q <= 1'b1;
        if (|imem_pc[1:0])
          state <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a behavioural 1-cycle instruction memory, a
// scoreboard of expected transfers, and a monitor that checks every transfer.
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_misaligned;
  logic [31:0] fetch_count;

  int applied     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  ifetch #(
    .PC_WIDTH  (32),
    .INST_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_pc       (imem_pc),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_misaligned (id_misaligned),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory contents: each aligned word encodes its own address; misaligned
  // reads return garbage that the DUT must replace with a NOP.
  function automatic logic [31:0] word(input logic [31:0] pc);
    if (pc[1:0] != 2'b00) return 32'hDEAD_BEEF;
    return {pc[15:0] ^ 16'hC0DE, pc[15:0]};
  endfunction

  always @(posedge clk) imem_inst <= word(imem_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.mis  = (pc[1:0] != 2'b00);
    e.inst = e.mis ? NOP : word(pc);
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL xfer_unexpected: got pc %08h expected no transfer", id_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("xfer pc=%08h inst=%08h mis=%0b (exp pc=%08h inst=%08h)",
                 id_pc, id_inst, id_misaligned, e.pc, e.inst);
        chk("xfer_pc",   id_pc,                 e.pc);
        chk("xfer_inst", id_inst,               e.inst);
        chk("xfer_mis",  {31'd0, id_misaligned}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid",   {31'd0, id_valid}, 32'd0);
    chk("rst_count",   fetch_count,       32'd0);
    chk("rst_imem_pc", imem_pc,           32'd0);

    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    cyc(); rst_n = 1'b1;
    cyc();                          // presenting 0
    cyc();                          // presenting 4
    cyc(); id_ready = 1'b0;         // presenting 8, stalled
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc",    id_pc,       32'h8);
      chk("stall_inst",  id_inst,     word(32'h8));
      chk("stall_count", fetch_count, 32'd2);
      if (i < 2) cyc();
    end
    cyc(); id_ready = 1'b1;         // 8 accepted
    cyc();                          // presenting 12
    push(32'h100); push(32'h104);
    cyc();                          // presenting 0x10, squashed
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_squash", {31'd0, id_valid}, 32'd0);
    cyc(); redirect_valid = 1'b0;   // presenting 0x100
    cyc();                          // presenting 0x104
    cyc();                          // presenting 0x108
    push(32'h180); push(32'h184);
    redirect_valid = 1'b1; redirect_pc = 32'h180; id_ready = 1'b0;
    @(negedge clk);
    chk("count_6",        fetch_count,       32'd6);
    chk("redir_stall_sq", {31'd0, id_valid}, 32'd0);
    cyc(); redirect_valid = 1'b0; id_ready = 1'b1;  // presenting 0x180
    cyc();                                          // presenting 0x184
    cyc();                                          // presenting 0x188
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    chk("count_8", fetch_count, 32'd8);
    push(32'h102);
    cyc(); redirect_valid = 1'b0; id_ready = 1'b0;  // presenting 0x102, held
    @(negedge clk);
    chk("mis_valid", {31'd0, id_valid},      32'd1);
    chk("mis_flag",  {31'd0, id_misaligned}, 32'd1);
    chk("mis_inst",  id_inst,                NOP);
    chk("mis_pc",    id_pc,                  32'h102);
    cyc(); id_ready = 1'b1;                         // 0x102 accepted
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("halt_valid", {31'd0, id_valid}, 32'd0);
      chk("halt_count", fetch_count,       32'd9);
    end
    push(32'h200); push(32'h204);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(); redirect_valid = 1'b0;                   // presenting 0x200
    cyc();                                          // presenting 0x204
    push(32'h38); push(32'h3C);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h38;  // 0x208 squashed
    cyc(); redirect_valid = 1'b0;                   // presenting 0x38
    cyc();                                          // presenting 0x3C
    cyc();                                          // presenting 0x40
    chk("pre_rst_pc", id_pc, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, id_valid}, 32'd0);
    chk("midrst_count", fetch_count,       32'd0);
    repeat (2) cyc();
    push(32'h0); push(32'h4);
    rst_n = 1'b1;
    cyc();                                          // presenting 0
    @(negedge clk);
    chk("restart_pc",    id_pc,       32'h0);
    chk("restart_count", fetch_count, 32'd0);
    cyc();                                          // presenting 4
    cyc(); id_ready = 1'b0;                         // presenting 8, not taken
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
